tpu_stream_tx: RTL and testbench

Host-side transmitter for the TPU input stream. Frames one matrix-multiply job (header, matrix A, matrix B) and drives it into the TPU's `valid`/`data_in`/`ready` port. Payload words come from an upstream producer over a valid/ready port. The block sits between the host or DMA logic and the TPU top. It is the sender for the interface the TPU controller receives.

---
 rtl/tpu_pkg.sv | 20 ++
 rtl/tpu_tx_slice.sv | 35 +++
 rtl/tpu_stream_tx.sv | 139 +++++++++++++
 tb/tb_tpu_stream_tx.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Definitions shared by the TPU stream transmitter and the TPU controller that decodes its header.
package tpu_pkg;

    localparam logic [7:0] TPU_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StLoadA,
        StLoadB,
        StDone,
        StErr
    } tx_state_t;

    function automatic logic [31:0] tpu_hdr(input logic [7:0] a, input logic [7:0] n,
                                            input logic [7:0] m);
        return {TPU_SYNC, m, n, a};
    endfunction

endpackage

// File: rtl/tpu_tx_slice.sv
// Single-entry output register for the TPU stream: holds a beat until the TPU accepts it.
module tpu_tx_slice (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] data
);

    logic        valid_q;
    logic [31:0] data_q;

    // Clear beats load so an aborting job never leaves a stale beat behind.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= 32'd0;
        end else if (clear) begin
            valid_q <= 1'b0;
            data_q  <= 32'd0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
        end else if (valid_q && ready) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/tpu_stream_tx.sv
// Frames one matrix-multiply job (header, A, B) from an upstream source onto the TPU input stream.
module tpu_stream_tx
    import tpu_pkg::*;
#(
    parameter int unsigned A = 4,
    parameter int unsigned N = 4,
    parameter int unsigned M = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cfg_a,
    input  logic [7:0]  cfg_n,
    input  logic [7:0]  cfg_m,
    input  logic        src_valid,
    input  logic [31:0] src_data,
    output logic        src_ready,
    output logic        tpu_valid,
    output logic [31:0] tpu_data,
    input  logic        tpu_ready,
    input  logic        tpu_err,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic        cfg_err
);

    localparam logic [7:0] AMax = 8'(A);
    localparam logic [7:0] NMax = 8'(N);
    localparam logic [7:0] MMax = 8'(M);

    tx_state_t   state_q, state_d;
    logic [15:0] src_cnt_q, src_cnt_d;
    logic [15:0] b_words_q, b_words_d;
    logic        src_b_q, src_b_d;
    logic        busy_q, done_q, aborted_q, cfg_err_q, cfg_err_d;
    logic        cfg_ok, in_stream, src_take, xfer;
    logic        slice_load, slice_clear;
    logic [31:0] slice_din;

    assign cfg_ok = (cfg_a >= 8'd1) && (cfg_a <= AMax) &&
                    (cfg_n >= 8'd1) && (cfg_n <= NMax) &&
                    (cfg_m >= 8'd1) && (cfg_m <= MMax);

    // The source is also taken while the header drains so words follow it without a bubble.
    assign in_stream = state_q inside {StHdr, StLoadA, StLoadB};
    assign src_ready = in_stream && (src_cnt_q != 16'd0) && (!tpu_valid || tpu_ready);
    assign src_take  = src_valid && src_ready;
    assign xfer      = tpu_valid && tpu_ready && !tpu_err;

    always_comb begin
        state_d     = state_q;
        src_cnt_d   = src_cnt_q;
        src_b_d     = src_b_q;
        b_words_d   = b_words_q;
        cfg_err_d   = 1'b0;
        slice_load  = 1'b0;
        slice_clear = 1'b0;
        slice_din   = src_data;

        // src_cnt counts the source words still owed in the current matrix.
        if (src_take) begin
            slice_load = 1'b1;
            if (!src_b_q && (src_cnt_q == 16'd1)) begin
                src_cnt_d = b_words_q;
                src_b_d   = 1'b1;
            end else begin
                src_cnt_d = src_cnt_q - 16'd1;
            end
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_ok) begin
                        state_d    = StHdr;
                        slice_load = 1'b1;
                        slice_din  = tpu_hdr(cfg_a, cfg_n, cfg_m);
                        src_cnt_d  = 16'(cfg_n) * 16'(cfg_a);
                        b_words_d  = 16'(cfg_a) * 16'(cfg_m);
                        src_b_d    = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StHdr: if (xfer) state_d = StLoadA;
            // Once the source is in B, the register can only hold the last A word.
            StLoadA: if (xfer && src_b_q) state_d = StLoadB;
            StLoadB: if (xfer && (src_cnt_q == 16'd0)) state_d = StDone;
            StDone, StErr: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (in_stream && tpu_err) begin
            state_d     = StErr;
            slice_clear = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            src_cnt_q <= 16'd0;
            b_words_q <= 16'd0;
            src_b_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_cnt_q <= src_cnt_d;
            b_words_q <= b_words_d;
            src_b_q   <= src_b_d;
            busy_q    <= (state_d != StIdle);
            done_q    <= (state_d == StDone);
            aborted_q <= (state_d == StErr);
            cfg_err_q <= cfg_err_d;
        end
    end

    tpu_tx_slice u_slice (
        .clk       (clk),
        .rst       (rst),
        .clear     (slice_clear),
        .load      (slice_load),
        .load_data (slice_din),
        .ready     (tpu_ready),
        .valid     (tpu_valid),
        .data      (tpu_data)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_tpu_stream_tx.sv
// Self-checking bench for tpu_stream_tx: config table, directed corner cases and random jobs.
module tb_tpu_stream_tx;

    localparam int JobBudget = 3000;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] n;
        logic [7:0] m;
        logic       exp_cfg_err;
        logic       exp_busy;
    } cfg_vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  cfg_a, cfg_n, cfg_m;
    logic        src_valid;
    logic [31:0] src_data;
    logic        src_ready;
    logic        tpu_valid;
    logic [31:0] tpu_data;
    logic        tpu_ready;
    logic        tpu_err;
    logic        busy, done, aborted, cfg_err;

    int          vectors, errors, cyc;
    int          first_xfer_cyc, last_xfer_cyc;
    int          done_cnt, cfg_err_cnt, aborted_cnt;
    logic        hold_pending;
    logic [31:0] hold_data;
    logic [31:0] got_q[$];
    logic [31:0] src_q[$];
    logic [31:0] pay[$];
    cfg_vec_t    vecs[10];

    tpu_stream_tx #(
        .A (4),
        .N (4),
        .M (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_a     (cfg_a),
        .cfg_n     (cfg_n),
        .cfg_m     (cfg_m),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .tpu_valid (tpu_valid),
        .tpu_data  (tpu_data),
        .tpu_ready (tpu_ready),
        .tpu_err   (tpu_err),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_hdr(input logic [7:0] a, input logic [7:0] n,
                                              input logic [7:0] m);
        return {8'hA5, m, n, a};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, "_busy"},      32'(busy),      32'd0);
        check({name, "_done"},      32'(done),      32'd0);
        check({name, "_aborted"},   32'(aborted),   32'd0);
        check({name, "_cfg_err"},   32'(cfg_err),   32'd0);
        check({name, "_tpu_valid"}, 32'(tpu_valid), 32'd0);
        check({name, "_tpu_data"},  tpu_data,       32'd0);
        check({name, "_src_ready"}, 32'(src_ready), 32'd0);
    endtask

    // Called at posedge+1 with inputs driven; observes the cycle, then advances one edge.
    task automatic cycle();
        #1;
        if (rst) begin
            if (tpu_valid && tpu_ready && !tpu_err) begin
                if (got_q.size() == 0) first_xfer_cyc = cyc;
                got_q.push_back(tpu_data);
                last_xfer_cyc = cyc;
            end
            if (src_valid && src_ready) src_q.push_back(src_data);
            if (hold_pending) begin
                check("hold_valid", 32'(tpu_valid), 32'd1);
                check("hold_data", tpu_data, hold_data);
            end
            if (tpu_valid && !tpu_ready) check("stall_src_ready", 32'(src_ready), 32'd0);
            hold_pending = tpu_valid && !tpu_ready && !tpu_err;
            hold_data    = tpu_data;
            if (done) begin
                done_cnt++;
                check("done_timing", cyc, last_xfer_cyc + 1);
            end
            if (cfg_err) cfg_err_cnt++;
            if (aborted) aborted_cnt++;
        end else begin
            hold_pending = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic make_payload(input int total, input bit counting);
        pay.delete();
        for (int i = 0; i < total; i++) pay.push_back(counting ? 32'(i + 1) : $urandom);
    endtask

    task automatic start_job(input logic [7:0] a, input logic [7:0] n, input logic [7:0] m);
        got_q.delete();
        src_q.delete();
        done_cnt    = 0;
        cfg_err_cnt = 0;
        aborted_cnt = 0;
        cfg_a       = a;
        cfg_n       = n;
        cfg_m       = m;
        start       = 1'b1;
        src_valid   = 1'b0;
        tpu_ready   = 1'b0;
        cycle();
        start = 1'b0;
    endtask

    // Drives the source and sink until done, stop_beat beats have transferred, or the budget ends.
    task automatic finish_job(input int vprob, input int rprob, input int stall_beat,
                              input int ign_beat, input int stop_beat);
        int budget;
        int stall_left;
        int idx;
        bit ign_done;
        logic [7:0] sa, sn, sm;
        budget     = 0;
        stall_left = 3;
        ign_done   = 1'b0;
        sa = cfg_a;
        sn = cfg_n;
        sm = cfg_m;
        while (done_cnt == 0 && got_q.size() < stop_beat && budget < JobBudget) begin
            idx       = src_q.size();
            src_valid = (idx < pay.size()) && (int'($urandom_range(99)) < vprob);
            src_data  = (idx < pay.size()) ? pay[idx] : $urandom;
            tpu_ready = (int'($urandom_range(99)) < rprob);
            if (got_q.size() == stall_beat && tpu_valid && stall_left > 0) begin
                tpu_ready = 1'b0;
                stall_left--;
            end
            if (got_q.size() == ign_beat && tpu_valid && !ign_done) begin
                start    = 1'b1;
                cfg_a    = 8'd1;
                cfg_n    = 8'd1;
                cfg_m    = 8'd1;
                ign_done = 1'b1;
            end else begin
                start = 1'b0;
                cfg_a = sa;
                cfg_n = sn;
                cfg_m = sm;
            end
            cycle();
            budget++;
        end
        start = 1'b0;
        cfg_a = sa;
        cfg_n = sn;
        cfg_m = sm;
        check("job_within_budget", 32'(budget < JobBudget), 32'd1);
    endtask

    task automatic check_stream(input logic [7:0] a, input logic [7:0] n, input logic [7:0] m);
        int total;
        logic [31:0] exp;
        logic [31:0] got;
        total = int'(n) * int'(a) + int'(a) * int'(m);
        check("stream_len", got_q.size(), 1 + total);
        check("src_count", src_q.size(), total);
        for (int i = 0; i <= total; i++) begin
            exp = (i == 0) ? model_hdr(a, n, m) : pay[i - 1];
            got = (i < got_q.size()) ? got_q[i] : 32'hx;
            check("stream_beat", got, exp);
        end
        check("done_once", done_cnt, 1);
        check("post_done_busy", 32'(busy), 32'd0);
        check("post_done_done", 32'(done), 32'd0);
    endtask

    initial begin
        vectors = 0;
        errors = 0;
        cyc = 0;
        first_xfer_cyc = 0;
        last_xfer_cyc = 0;
        hold_pending = 1'b0;
        hold_data = 32'd0;
        rst = 1'b0;
        start = 1'b0;
        cfg_a = 8'd0;
        cfg_n = 8'd0;
        cfg_m = 8'd0;
        src_valid = 1'b0;
        src_data = 32'd0;
        tpu_ready = 1'b0;
        tpu_err = 1'b0;

        vecs[0] = '{a: 8'd2,   n: 8'd2,   m: 8'd2,   exp_cfg_err: 1'b0, exp_busy: 1'b1};
        vecs[1] = '{a: 8'd1,   n: 8'd5,   m: 8'd1,   exp_cfg_err: 1'b1, exp_busy: 1'b0};
        vecs[2] = '{a: 8'd0,   n: 8'd1,   m: 8'd1,   exp_cfg_err: 1'b1, exp_busy: 1'b0};
        vecs[3] = '{a: 8'd5,   n: 8'd1,   m: 8'd1,   exp_cfg_err: 1'b1, exp_busy: 1'b0};
        vecs[4] = '{a: 8'd1,   n: 8'd1,   m: 8'd5,   exp_cfg_err: 1'b1, exp_busy: 1'b0};
        vecs[5] = '{a: 8'd1,   n: 8'd0,   m: 8'd1,   exp_cfg_err: 1'b1, exp_busy: 1'b0};
        vecs[6] = '{a: 8'd4,   n: 8'd4,   m: 8'd4,   exp_cfg_err: 1'b0, exp_busy: 1'b1};
        vecs[7] = '{a: 8'd1,   n: 8'd1,   m: 8'd1,   exp_cfg_err: 1'b0, exp_busy: 1'b1};
        vecs[8] = '{a: 8'd255, n: 8'd255, m: 8'd255, exp_cfg_err: 1'b1, exp_busy: 1'b0};
        vecs[9] = '{a: 8'd4,   n: 8'd1,   m: 8'd0,   exp_cfg_err: 1'b1, exp_busy: 1'b0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b1;
        check_quiet("reset");

        // Basic job: words 1..8 follow the header back to back.
        make_payload(8, 1'b1);
        start_job(8'd2, 8'd2, 8'd2);
        check("start_busy", 32'(busy), 32'd1);
        check("start_valid", 32'(tpu_valid), 32'd1);
        check("start_hdr", tpu_data, 32'hA5020202);
        finish_job(100, 100, -1, -1, 1000);
        check_stream(8'd2, 8'd2, 8'd2);
        check("basic_back_to_back", last_xfer_cyc - first_xfer_cyc, 8);

        // Backpressure: word 3 is stalled for three cycles.
        make_payload(8, 1'b1);
        start_job(8'd2, 8'd2, 8'd2);
        finish_job(100, 100, 3, -1, 1000);
        check_stream(8'd2, 8'd2, 8'd2);
        check("stall_length", last_xfer_cyc - first_xfer_cyc, 11);

        // Configuration table, including the dimension boundaries.
        for (int i = 0; i < 10; i++) begin
            make_payload(int'(vecs[i].n) * int'(vecs[i].a) + int'(vecs[i].a) * int'(vecs[i].m),
                         1'b0);
            start_job(vecs[i].a, vecs[i].n, vecs[i].m);
            check("tbl_cfg_err", 32'(cfg_err), 32'(vecs[i].exp_cfg_err));
            check("tbl_busy", 32'(busy), 32'(vecs[i].exp_busy));
            check("tbl_valid", 32'(tpu_valid), 32'(vecs[i].exp_busy));
            if (vecs[i].exp_busy) begin
                check("tbl_hdr", tpu_data, model_hdr(vecs[i].a, vecs[i].n, vecs[i].m));
                finish_job(70, 70, -1, -1, 1000);
                check_stream(vecs[i].a, vecs[i].n, vecs[i].m);
            end else begin
                cycle();
                check("tbl_rej_busy", 32'(busy), 32'd0);
                check("tbl_rej_valid", 32'(tpu_valid), 32'd0);
                check("tbl_rej_pulse", 32'(cfg_err), 32'd0);
            end
        end

        // Start during LOAD_A is ignored and raises no cfg_err.
        make_payload(18, 1'b0);
        start_job(8'd3, 8'd3, 8'd3);
        finish_job(80, 80, -1, 3, 1000);
        check_stream(8'd3, 8'd3, 8'd3);
        check("ignored_start_cfg_err", cfg_err_cnt, 0);

        // TPU error after the sixth A word transfers.
        make_payload(32, 1'b0);
        start_job(8'd4, 8'd4, 8'd4);
        finish_job(100, 100, -1, -1, 7);
        check("err_setup_beats", got_q.size(), 7);
        tpu_err   = 1'b1;
        tpu_ready = 1'b1;
        cycle();
        tpu_err   = 1'b0;
        src_valid = 1'b0;
        check("err_valid", 32'(tpu_valid), 32'd0);
        check("err_data", tpu_data, 32'd0);
        check("err_aborted", 32'(aborted), 32'd1);
        check("err_busy", 32'(busy), 32'd1);
        cycle();
        check("err_aborted_pulse", 32'(aborted), 32'd0);
        check("err_idle", 32'(busy), 32'd0);
        check("err_no_done", done_cnt, 0);

        make_payload(8, 1'b1);
        start_job(8'd2, 8'd2, 8'd2);
        check("restart_hdr", tpu_data, 32'hA5020202);
        finish_job(100, 100, -1, -1, 1000);
        check_stream(8'd2, 8'd2, 8'd2);

        // Reset while in LOAD_B.
        make_payload(8, 1'b1);
        start_job(8'd2, 8'd2, 8'd2);
        finish_job(100, 100, -1, -1, 6);
        check("rst_setup_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        check_quiet("midjob_reset");
        src_valid = 1'b1;
        tpu_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        check("rst_no_done", done_cnt, 0);
        check("rst_stays_idle", 32'(busy), 32'd0);

        // Random jobs with random source and sink pacing.
        for (int j = 0; j < 8; j++) begin
            logic [7:0] ra, rn, rm;
            ra = 8'($urandom_range(1, 4));
            rn = 8'($urandom_range(1, 4));
            rm = 8'($urandom_range(1, 4));
            make_payload(int'(rn) * int'(ra) + int'(ra) * int'(rm), 1'b0);
            start_job(ra, rn, rm);
            finish_job(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), -1, -1, 1000);
            check_stream(ra, rn, rm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
